// File: rtl/hilo_acc_if.sv
// Execute-stage handshake bundle between pipeline control and the HI/LO accumulator.
interface hilo_acc_if;
    logic        ACCEn;
    logic        MULSelB;
    logic [5:0]  Func;
    logic [63:0] MULout;
    logic [31:0] RegB;
    logic [31:0] ACCout;
    logic        ACCO;
    logic        ACCZ;
    logic        ACCN;
    logic        ACCC;
    logic        Stall;

    modport master (
        output ACCEn, MULSelB, Func, MULout, RegB,
        input  ACCout, ACCO, ACCZ, ACCN, ACCC, Stall
    );

    modport slave (
        input  ACCEn, MULSelB, Func, MULout, RegB,
        output ACCout, ACCO, ACCZ, ACCN, ACCC, Stall
    );
endinterface

// File: rtl/hilo_acc.sv
// HI/LO accumulator: MULT, MADD/MSUB family as a two-cycle split add, MTHI/MTLO, MFHI/MFLO.
// Define HILO_ACC_FWD_EN to forward the in-flight HI result to MFHI instead of stalling.
//
// state  | meaning
// IDLE   | no accumulate in flight
// ACC_HI | HI half of an accumulate completes this cycle
module hilo_acc (
    input  logic         clk,
    input  logic         rst,
    hilo_acc_if.slave    acc
);
    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MADDU = 6'h01;
    localparam logic [5:0] F_MSUB  = 6'h04;
    localparam logic [5:0] F_MSUBU = 6'h05;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

`ifdef HILO_ACC_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic {IDLE, ACC_HI} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_q, pend_d;
    logic        cy_q, cy_d;
    logic        sub_q, sub_d;
    logic        sgn_q, sgn_d;
    logic        acco_q, acco_d;
    logic        accc_q, accc_d;

    logic [63:0] src;
    logic [32:0] lo_sum;
    logic [32:0] hi_sum;
    logic        ovf;
    logic        is_madd;
    logic        op_sub;
    logic        op_sgn;
    logic        stall;
    logic        op;
    logic [31:0] acc_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
            cy_q    <= 1'b0;
            sub_q   <= 1'b0;
            sgn_q   <= 1'b0;
            acco_q  <= 1'b0;
            accc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            cy_q    <= cy_d;
            sub_q   <= sub_d;
            sgn_q   <= sgn_d;
            acco_q  <= acco_d;
            accc_q  <= accc_d;
        end
    end

    always_comb begin
        src     = acc.MULSelB ? acc.MULout : {acc.RegB, acc.RegB};
        is_madd = (acc.Func == F_MADD) || (acc.Func == F_MADDU) ||
                  (acc.Func == F_MSUB) || (acc.Func == F_MSUBU);
        op_sub  = (acc.Func == F_MSUB) || (acc.Func == F_MSUBU);
        op_sgn  = (acc.Func == F_MADD) || (acc.Func == F_MSUB);

        lo_sum = op_sub ? ({1'b0, lo_q} - {1'b0, src[31:0]})
                        : ({1'b0, lo_q} + {1'b0, src[31:0]});
        // Bit 32 is carry for add and borrow for subtract, so it chains straight into the HI half.
        hi_sum = sub_q ? ({1'b0, hi_q} - {1'b0, pend_q} - {32'b0, cy_q})
                       : ({1'b0, hi_q} + {1'b0, pend_q} + {32'b0, cy_q});
        ovf    = sub_q ? ((hi_q[31] != pend_q[31]) && (hi_sum[31] != hi_q[31]))
                       : ((hi_q[31] == pend_q[31]) && (hi_sum[31] != hi_q[31]));

        stall = (state_q == ACC_HI) && acc.ACCEn &&
                !((acc.Func == F_MFLO) || (acc.Func == F_MTLO) ||
                  (FWD_EN && (acc.Func == F_MFHI)));
        op    = acc.ACCEn && !stall;

        state_d = IDLE;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        cy_d    = cy_q;
        sub_d   = sub_q;
        sgn_d   = sgn_q;
        acco_d  = acco_q;
        accc_d  = accc_q;

        if (state_q == ACC_HI) begin
            hi_d   = hi_sum[31:0];
            acco_d = sgn_q && ovf;
            accc_d = !sgn_q && hi_sum[32];
        end

        if (op) begin
            if ((acc.Func == F_MULT) || (acc.Func == F_MULTU)) begin
                hi_d   = acc.MULout[63:32];
                lo_d   = acc.MULout[31:0];
                acco_d = 1'b0;
                accc_d = 1'b0;
            end else if (is_madd) begin
                lo_d    = lo_sum[31:0];
                cy_d    = lo_sum[32];
                pend_d  = src[63:32];
                sub_d   = op_sub;
                sgn_d   = op_sgn;
                state_d = ACC_HI;
            end else if (acc.Func == F_MTHI) begin
                hi_d = acc.RegB;
            end else if (acc.Func == F_MTLO) begin
                lo_d = acc.RegB;
            end
        end

        acc_out = '0;
        if (acc.ACCEn && (acc.Func == F_MFHI))
            acc_out = (FWD_EN && (state_q == ACC_HI)) ? hi_sum[31:0] : hi_q;
        else if (acc.ACCEn && (acc.Func == F_MFLO))
            acc_out = lo_q;
    end

    assign acc.ACCout = acc_out;
    assign acc.ACCZ   = (acc_out == 32'h0);
    assign acc.ACCN   = acc_out[31];
    assign acc.ACCO   = acco_q;
    assign acc.ACCC   = accc_q;
    assign acc.Stall  = stall;
endmodule

// File: tb/tb_hilo_acc.sv
// Bench for hilo_acc: directed and random ops, 64-bit arithmetic reference model, queued read expectations.
module tb_hilo_acc;
    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MADDU = 6'h01;
    localparam logic [5:0] F_MSUB  = 6'h04;
    localparam logic [5:0] F_MSUBU = 6'h05;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

`ifdef HILO_ACC_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          chk_flags;
        bit          acco;
        bit          accc;
    } exp_t;

    logic clk;
    logic rst;
    hilo_acc_if bif ();

    hilo_acc dut (.clk(clk), .rst(rst), .acc(bif));

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    bit mon_en = 0;

    logic [63:0] m_acc;
    bit          m_acco, m_accc, m_pend;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic void model_reset();
        m_acc = '0; m_acco = 0; m_accc = 0; m_pend = 0;
    endfunction

    // Whole-op reference: the 64-bit accumulate is applied at once; flags are only
    // checkable by a read that happens after the HI half has completed.
    function automatic void model_step(input bit en, input logic [5:0] f, input bit sel,
                                       input logic [63:0] mul, input logic [31:0] rb);
        bit was_pend;
        logic [63:0] src, r;
        logic [64:0] wide;
        exp_t e;
        was_pend = m_pend;
        m_pend = 0;
        if (!en) return;
        src = sel ? mul : {rb, rb};
        case (f)
            F_MULT, F_MULTU: begin m_acc = mul; m_acco = 0; m_accc = 0; end
            F_MADD, F_MADDU: begin
                wide = {1'b0, m_acc} + {1'b0, src};
                r = wide[63:0];
                m_acco = (f == F_MADD) && (m_acc[63] == src[63]) && (r[63] != m_acc[63]);
                m_accc = (f == F_MADDU) && wide[64];
                m_acc = r; m_pend = 1;
            end
            F_MSUB, F_MSUBU: begin
                r = m_acc - src;
                m_acco = (f == F_MSUB) && (m_acc[63] != src[63]) && (r[63] != m_acc[63]);
                m_accc = (f == F_MSUBU) && (m_acc < src);
                m_acc = r; m_pend = 1;
            end
            F_MTHI: m_acc[63:32] = rb;
            F_MTLO: m_acc[31:0]  = rb;
            F_MFHI, F_MFLO: begin
                e.data = (f == F_MFHI) ? m_acc[63:32] : m_acc[31:0];
                e.chk_flags = !was_pend;
                e.acco = m_acco;
                e.accc = m_accc;
                sb.push_back(e);
            end
            default: ;
        endcase
    endfunction

    task automatic do_op(input bit en, input logic [5:0] f, input bit sel,
                         input logic [63:0] mul, input logic [31:0] rb);
        bit exp_stall;
        do begin
            @(negedge clk);
            exp_stall = en && m_pend &&
                        !((f == F_MFLO) || (f == F_MTLO) || (FWD_EN && (f == F_MFHI)));
            bif.ACCEn = en; bif.Func = f; bif.MULSelB = sel; bif.MULout = mul; bif.RegB = rb;
            if (exp_stall) m_pend = 0;
            else model_step(en, f, sel, mul, rb);
            #1;
            check("stall", {63'b0, bif.Stall}, {63'b0, exp_stall});
        end while (exp_stall);
    endtask

    task automatic set_hilo(input logic [31:0] hi, input logic [31:0] lo);
        do_op(1, F_MTHI, 0, '0, hi);
        do_op(1, F_MTLO, 0, '0, lo);
    endtask

    task automatic read_both();
        do_op(1, F_MFHI, 0, '0, '0);
        do_op(1, F_MFLO, 0, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_op(0, 6'h3F, 0, '0, '0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && bif.ACCEn && !bif.Stall &&
                ((bif.Func == F_MFHI) || (bif.Func == F_MFLO))) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL read_unexpected got=%h want=none", bif.ACCout);
                end else begin
                    e = sb.pop_front();
                    check("accout", {32'b0, bif.ACCout}, {32'b0, e.data});
                    check("accz", {63'b0, bif.ACCZ}, {63'b0, (e.data == 32'h0)});
                    check("accn", {63'b0, bif.ACCN}, {63'b0, e.data[31]});
                    if (e.chk_flags) begin
                        check("acco", {63'b0, bif.ACCO}, {63'b0, e.acco});
                        check("accc", {63'b0, bif.ACCC}, {63'b0, e.accc});
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0] funcs [11];
        logic [5:0] f;
        funcs = '{F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_MULT, F_MULTU,
                  F_MADD, F_MADDU, F_MSUB, F_MSUBU, 6'h2A};
        bif.ACCEn = 0; bif.Func = '0; bif.MULSelB = 0; bif.MULout = '0; bif.RegB = '0;
        rst = 1;
        model_reset();
        #12;
        rst = 0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_stall", {63'b0, bif.Stall}, 64'h0);
        check("rst_acco",  {63'b0, bif.ACCO}, 64'h0);
        check("rst_accc",  {63'b0, bif.ACCC}, 64'h0);
        check("rst_accout", {32'b0, bif.ACCout}, 64'h0);
        check("rst_accz",  {63'b0, bif.ACCZ}, 64'h1);
        mon_en = 1;
        read_both();

        // Unsigned add carrying from LO into HI
        set_hilo(32'h0, 32'hFFFF_FFFF);
        do_op(1, F_MADDU, 1, 64'h1, '0);
        idle(2);
        read_both();

        // Unsigned subtract borrowing through zero
        set_hilo(32'h0, 32'h0);
        do_op(1, F_MSUBU, 1, 64'h1, '0);
        idle(2);
        read_both();

        // Signed positive overflow
        set_hilo(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        do_op(1, F_MADD, 1, 64'h1, '0);
        idle(2);
        read_both();

        // Back-to-back reads against an in-flight accumulate
        set_hilo(32'h1234_0000, 32'hFFFF_FFF0);
        do_op(1, F_MADD, 1, 64'h0000_0001_0000_0020, '0);
        do_op(1, F_MFHI, 0, '0, '0);
        do_op(1, F_MFLO, 0, '0, '0);
        do_op(1, F_MSUBU, 0, '0, 32'h0000_0100);
        do_op(1, F_MFLO, 0, '0, '0);
        do_op(1, F_MFHI, 0, '0, '0);
        do_op(1, F_MADDU, 1, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        do_op(1, F_MTLO, 0, '0, 32'hCAFE_F00D);
        read_both();
        do_op(1, F_MSUB, 1, 64'h8000_0000_0000_0000, '0);
        do_op(1, F_MULT, 1, 64'hDEAD_BEEF_0BAD_F00D, '0);
        read_both();

        // Reset in the middle of an accumulate
        do_op(1, F_MULT, 1, 64'h1234_5678_9ABC_DEF0, '0);
        do_op(1, F_MADD, 1, 64'h1, '0);
        mon_en = 0;
        @(negedge clk);
        bif.ACCEn = 1; bif.Func = F_MFHI;
        #1;
        rst = 1;
        #1;
        check("midrst_stall", {63'b0, bif.Stall}, 64'h0);
        check("midrst_hi", {32'b0, bif.ACCout}, 64'h0);
        bif.Func = F_MFLO;
        #1;
        check("midrst_lo", {32'b0, bif.ACCout}, 64'h0);
        rst = 0;
        bif.ACCEn = 0;
        model_reset();
        mon_en = 1;
        read_both();

        // Random mix
        for (int i = 0; i < 600; i++) begin
            f = funcs[$urandom_range(0, 10)];
            do_op(($urandom_range(0, 7) != 0), f, $urandom_range(0, 1),
                  {rnd32(), rnd32()}, rnd32());
        end
        idle(3);
        read_both();
        idle(2);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_acc.md
Name: hilo_acc

Overview:
- HI/LO accumulator unit in the execute stage. It is the consumer of the ACCEn/MULSelB controls driven by execute control, and the producer of ACCout and the ACC flags (ACCO/ACCZ/ACCN/ACCC).
- Holds the architectural HI and LO registers and executes MULT/MULTU, MADD/MADDU/MSUB/MSUBU, MTHI/MTLO and MFHI/MFLO.
- Each 64-bit accumulate runs as a two-cycle split add: LO in the first cycle, HI plus carry in the second. A stall handshake back to the pipeline covers the HI hazard.

Parameters:
- None. Width is fixed at 32 bits; the HI:LO pair is 64 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- ACCEn  in  1  accumulator operation valid this cycle
- MULSelB  in  1  data source: 1 = MULout, 0 = RegB (MTHI/MTLO)
- Func  in  6  function code; encodings from mul_definition.sv
- MULout  in  64  multiplier product, sign already applied for signed ops
- RegB  in  32  register operand for MTHI/MTLO
- ACCout  out  32  read data
- ACCO  out  1  overflow flag
- ACCZ  out  1  zero flag
- ACCN  out  1  negative flag
- ACCC  out  1  carry/borrow flag
- Stall  out  1  pipeline must hold the current ACC op and re-present it next cycle

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-high.
- Reset values: HI=0, LO=0, state=IDLE, pending-high register=0, carry bit=0, ACCO=0, ACCC=0. Stall=0 and ACCout=0 follow from reset state.
- Effective op: Op = ACCEn & ~Stall. If Stall=1 the op has no effect on any state.
- Source: Src = MULSelB ? MULout : {RegB,RegB}.
- States:
  - IDLE: no accumulate in flight.
  - ACC_HI: HI half of an accumulate in flight.
- MULT/MULTU (any state, when not stalled): HI<=MULout[63:32], LO<=MULout[31:0]. Single cycle. ACCO and ACCC cleared. State -> IDLE.
- MADD/MADDU/MSUB/MSUBU, cycle 1:
  - {cy,LO} <= LO +/- Src[31:0].
  - For subtract, cy is the borrow.
  - Capture Src[63:32] into the pending-high register, plus op type (add/sub, signed/unsigned).
  - State -> ACC_HI.
- ACC_HI, cycle 2 (unconditional):
  - HI <= HI +/- pending +/- cy.
  - Signed ops: ACCO <= 64-bit two's-complement overflow; ACCC <= 0.
  - Unsigned ops: ACCC <= 64-bit carry-out (add) or borrow (sub); ACCO <= 0.
  - State -> IDLE, unless a new MADD-family op is accepted the same cycle (not possible; see Stall).
- MTHI: HI<=RegB. MTLO: LO<=RegB. One cycle each; flags unchanged.
- MFHI: ACCout = HI. MFLO: ACCout = LO. Combinational. Any other op or ACCEn=0: ACCout = 0.
- Flags:
  - ACCZ = (ACCout==0) and ACCN = ACCout[31], both combinational.
  - ACCO and ACCC are registered, from the last completed accumulate.
- Stall (combinational) = state==ACC_HI & ACCEn & Func is not in {MFLO, MTLO}. Stall is high for exactly one cycle.
- Simultaneous events:
  - MFLO in ACC_HI: sees the LO already updated in cycle 1. No stall.
  - MTLO in ACC_HI: writes LO. The pending HI completion proceeds. No stall.
- Reset mid-accumulate (rst in ACC_HI): the pending HI half is discarded and all state returns to reset values immediately.
- Func codes with ACCEn=1 outside the listed set: no state change; ACCout=0.

Optional Feature:
- Macro: HILO_ACC_FWD_EN.
- Defined: MFHI in ACC_HI does not stall. ACCout forwards the HI value being computed that cycle (HI +/- pending +/- cy), and ACCZ/ACCN follow the forwarded value. Stall excludes MFHI in addition to MFLO/MTLO.
- Undefined: MFHI in ACC_HI stalls one cycle as specified above.

Test Plan:
1. rst pulse, then MFHI and MFLO -> ACCout=0 for both, ACCZ=1, ACCO=0, ACCC=0, Stall=0.
2. MTLO RegB=0xFFFFFFFF; MTHI RegB=0; MADDU MULout=0x1; wait 2 cycles; MFHI/MFLO -> HI=0x00000001, LO=0x00000000, ACCC=0.
3. HI:LO=0; MSUBU MULout=0x1 -> after 2 cycles HI=LO=0xFFFFFFFF, ACCC=1, ACCO=0; MFLO gives ACCN=1.
4. HI:LO=0x7FFFFFFF_FFFFFFFF; MADD MULout=0x1 -> HI=0x80000000, LO=0, ACCO=1, ACCC=0.
5. MADD then MFHI on the next cycle:
   - without HILO_ACC_FWD_EN: Stall=1 for one cycle, then ACCout = new HI;
   - with it: Stall=0 and ACCout = new HI in that same cycle.
   - MFLO on the next cycle instead: Stall=0, new LO.
6. MULT MULout=0x12345678_9ABCDEF0, then MADD, then rst asserted in ACC_HI -> HI=LO=0 immediately, state IDLE, Stall=0; a subsequent MFHI returns 0.
